// File: rtl/gumnut_fetch_unit.sv
// gumnut_fetch_unit: instruction fetch, PC, return stack and saved interrupt PC
// for the Gumnut core. Follows the external FSM state on state_i.
// Optional feature macro: GUMNUT_FETCH_STACK_ERR_EN (return-stack entry count
// and sticky overflow/underflow flag on stack_err_o).
module gumnut_fetch_unit #(
    parameter int unsigned STACK_DEPTH = 8,
    parameter logic [11:0] INT_VECTOR  = 12'h001
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  state_i,
    input  logic        zero_i,
    input  logic        carry_i,
    output logic        inst_cyc_o,
    output logic        inst_stb_o,
    output logic [11:0] inst_adr_o,
    input  logic [17:0] inst_dat_i,
    input  logic        inst_ack_i,
    output logic [17:0] ir_o,
    output logic [11:0] pc_o,
    output logic        stack_err_o
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH);
    localparam int unsigned CNT_W = SP_W + 1;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_MEM       = 3'b011,
        ST_WRITEBACK = 3'b100,
        ST_INT       = 3'b101
    } fsm_state_e;

    fsm_state_e        state;
    logic [11:0]       pc_q, pc_d;
    logic [17:0]       ir_q, ir_d;
    logic [11:0]       int_pc_q, int_pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [SP_W-1:0]   sp_m1;
    logic [11:0]       stack_q [STACK_DEPTH];
    logic              push, pop;
    logic              taken;
    logic              pop_empty;

    assign state      = fsm_state_e'(state_i);
    assign inst_cyc_o = (state_i == ST_FETCH) && !rst_i;
    assign inst_stb_o = (state_i == ST_FETCH) && !rst_i;
    assign inst_adr_o = pc_q;
    assign pc_o       = pc_q;
    assign ir_o       = ir_q;
    assign sp_m1      = sp_q - SP_W'(1);

    // Branch condition selected by ir[11:10]: bz, bnz, bc, bnc
    always_comb begin
        taken = 1'b0;
        case (ir_q[11:10])
            2'b00:   taken = zero_i;
            2'b01:   taken = !zero_i;
            2'b10:   taken = carry_i;
            default: taken = !carry_i;
        endcase
    end

    // Next-state for PC, IR, saved interrupt PC and stack pointer
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        int_pc_d = int_pc_q;
        sp_d     = sp_q;
        push     = 1'b0;
        pop      = 1'b0;
        case (state)
            ST_FETCH: begin
                if (inst_ack_i) begin
                    ir_d = inst_dat_i;
                    pc_d = pc_q + 12'd1;
                end
            end
            ST_DECODE: begin
                if (ir_q[17:12] == 6'b111110) begin
                    if (taken) pc_d = pc_q + {{4{ir_q[7]}}, ir_q[7:0]};
                end else if (ir_q[17:13] == 5'b11110) begin
                    push = ir_q[12];
                    pc_d = ir_q[11:0];
                end else if (ir_q[17:11] == 7'b1111110) begin
                    if (ir_q[10:8] == 3'b000) begin
                        pop  = 1'b1;
                        pc_d = pop_empty ? '0 : stack_q[sp_m1];
                    end else if (ir_q[10:8] == 3'b001) begin
                        pc_d = int_pc_q;
                    end
                end
            end
            ST_INT: begin
                int_pc_d = pc_q;
                pc_d     = INT_VECTOR;
            end
            default: ;
        endcase
        if (push) sp_d = sp_q + SP_W'(1);
        if (pop)  sp_d = sp_m1;
    end

    // Architectural registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q     <= '0;
            ir_q     <= '0;
            int_pc_q <= '0;
            sp_q     <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            int_pc_q <= int_pc_d;
            sp_q     <= sp_d;
        end
    end

    // Return-stack storage; no reset, write blocked while reset is held
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) stack_q[sp_q] <= pc_q;
    end

`ifdef GUMNUT_FETCH_STACK_ERR_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign pop_empty   = (cnt_q == '0);
    assign stack_err_o = err_q;

    // Saturating entry count; overflow/underflow set the sticky error
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (push) begin
            if (cnt_q == CNT_W'(STACK_DEPTH)) err_d = 1'b1;
            else                              cnt_d = cnt_q + CNT_W'(1);
        end
        if (pop) begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count and error registers, cleared only by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign pop_empty   = 1'b0;
    assign stack_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gumnut_fetch_unit.sv
// Self-checking bench for gumnut_fetch_unit: directed scenarios plus a
// randomized run against a cycle-level behavioural model of the fetch stage.
module tb_gumnut_fetch_unit;

    localparam int          DEPTH = 8;
    localparam logic [11:0] INTV  = 12'h001;
`ifdef GUMNUT_FETCH_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [17:0] RET  = 18'h3F000;
    localparam logic [17:0] RETI = 18'h3F100;
    localparam logic [17:0] WAIT = 18'h3F200;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  state_i = 3'd0;
    logic        zero_i = 1'b0, carry_i = 1'b0;
    logic        inst_cyc_o, inst_stb_o;
    logic [11:0] inst_adr_o, pc_o;
    logic [17:0] inst_dat_i = '0;
    logic        inst_ack_i = 1'b0;
    logic [17:0] ir_o;
    logic        stack_err_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [11:0] m_pc, m_int_pc;
    logic [17:0] m_ir;
    logic [11:0] m_stk [DEPTH];
    int          m_sp, m_cnt;
    logic        m_err;

    // Values sampled mid-cycle, before the active edge
    logic s_stb, s_cyc;
    logic [11:0] s_pc;

    gumnut_fetch_unit #(.STACK_DEPTH(DEPTH), .INT_VECTOR(INTV)) dut (
        .clk_i(clk), .rst_i(rst_i), .state_i(state_i), .zero_i(zero_i),
        .carry_i(carry_i), .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o),
        .inst_adr_o(inst_adr_o), .inst_dat_i(inst_dat_i), .inst_ack_i(inst_ack_i),
        .ir_o(ir_o), .pc_o(pc_o), .stack_err_o(stack_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] jmp(input logic [11:0] a);
        return {6'b111100, a};
    endfunction
    function automatic logic [17:0] jsb(input logic [11:0] a);
        return {6'b111101, a};
    endfunction
    function automatic logic [17:0] br(input logic [1:0] cc, input logic [7:0] d);
        return {6'b111110, cc, 2'b00, d};
    endfunction

    task automatic model_reset();
        m_pc = '0; m_ir = '0; m_int_pc = '0; m_sp = 0; m_cnt = 0; m_err = 1'b0;
    endtask

    task automatic model_update(input logic [2:0] st, input logic ack, input logic [17:0] dat,
                                input logic z, input logic c);
        logic t;
        int   d;
        case (st)
            3'd0: if (ack) begin m_ir = dat; m_pc = m_pc + 12'd1; end
            3'd1: begin
                if (m_ir[17:12] == 6'b111110) begin
                    case (m_ir[11:10])
                        2'd0: t = z;
                        2'd1: t = !z;
                        2'd2: t = c;
                        default: t = !c;
                    endcase
                    d = $signed(m_ir[7:0]);
                    if (t) m_pc = 12'((int'(m_pc) + d + 4096) % 4096);
                end else if (m_ir[17:13] == 5'b11110) begin
                    if (m_ir[12]) begin
                        if (ERR_EN && m_cnt == DEPTH) m_err = 1'b1;
                        m_stk[m_sp] = m_pc;
                        m_sp = (m_sp + 1) % DEPTH;
                        if (m_cnt < DEPTH) m_cnt++;
                    end
                    m_pc = m_ir[11:0];
                end else if (m_ir[17:11] == 7'b1111110) begin
                    if (m_ir[10:8] == 3'd0) begin
                        m_sp = (m_sp + DEPTH - 1) % DEPTH;
                        if (ERR_EN && m_cnt == 0) begin m_err = 1'b1; m_pc = '0; end
                        else m_pc = m_stk[m_sp];
                        if (m_cnt > 0) m_cnt--;
                    end else if (m_ir[10:8] == 3'd1) begin
                        m_pc = m_int_pc;
                    end
                end
            end
            3'd5: begin m_int_pc = m_pc; m_pc = INTV; end
            default: ;
        endcase
    endtask

    // One clock cycle: drive inputs, sample strobe mid-cycle, advance model, pass edge
    task automatic step(input logic [2:0] st, input logic ack, input logic [17:0] dat,
                        input logic z, input logic c);
        state_i = st; inst_ack_i = ack; inst_dat_i = dat; zero_i = z; carry_i = c;
        #2;
        s_stb = inst_stb_o; s_cyc = inst_cyc_o; s_pc = pc_o;
        model_update(st, ack, dat, z, c);
        @(posedge clk); #1;
    endtask

    task automatic goto_pc(input logic [11:0] a);
        step(3'd0, 1'b1, jmp(a), 1'b0, 1'b0);
        step(3'd1, 1'b0, 18'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; state_i = 3'd0; inst_ack_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (inst_stb_o !== 1'b0) begin n_err++; $display("FAIL reset_stb got %b want 0", inst_stb_o); end
        n_vec++; if (pc_o !== 12'h000) begin n_err++; $display("FAIL reset_pc got %h want 000", pc_o); end
        n_vec++; if (ir_o !== 18'h0) begin n_err++; $display("FAIL reset_ir got %h want 0", ir_o); end
        n_vec++; if (stack_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", stack_err_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_late_ack();
        for (int i = 0; i < 2; i++) begin
            step(3'd0, 1'b0, 18'h00123, 1'b0, 1'b0);
            n_vec++; if (s_stb !== 1'b1) begin n_err++; $display("FAIL late_stb%0d got %b want 1", i, s_stb); end
            n_vec++; if (pc_o !== 12'h000) begin n_err++; $display("FAIL late_pc_hold%0d got %h want 000", i, pc_o); end
        end
        step(3'd0, 1'b1, 18'h00123, 1'b0, 1'b0);
        n_vec++; if (s_stb !== 1'b1 || s_cyc !== 1'b1) begin n_err++; $display("FAIL late_stb_ack got %b/%b want 1/1", s_stb, s_cyc); end
        n_vec++; if (ir_o !== 18'h00123) begin n_err++; $display("FAIL late_ir got %h want 00123", ir_o); end
        n_vec++; if (pc_o !== 12'h001) begin n_err++; $display("FAIL late_pc got %h want 001", pc_o); end
    endtask

    task automatic test_pc_wrap();
        goto_pc(12'hFFF);
        n_vec++; if (pc_o !== 12'hFFF) begin n_err++; $display("FAIL jmp_fff got %h want fff", pc_o); end
        step(3'd0, 1'b1, 18'h0, 1'b0, 1'b0);
        n_vec++; if (pc_o !== 12'h000) begin n_err++; $display("FAIL pc_wrap got %h want 000", pc_o); end
        n_vec++; if (inst_adr_o !== 12'h000) begin n_err++; $display("FAIL adr_wrap got %h want 000", inst_adr_o); end
    endtask

    task automatic test_branch();
        goto_pc(12'h00F);
        step(3'd0, 1'b1, br(2'b00, 8'hFC), 1'b0, 1'b0);
        step(3'd1, 1'b0, 18'h0, 1'b1, 1'b0);
        n_vec++; if (pc_o !== 12'h00C) begin n_err++; $display("FAIL bz_taken got %h want 00c", pc_o); end
        goto_pc(12'h00F);
        step(3'd0, 1'b1, br(2'b00, 8'hFC), 1'b0, 1'b0);
        step(3'd1, 1'b0, 18'h0, 1'b0, 1'b1);
        n_vec++; if (pc_o !== 12'h010) begin n_err++; $display("FAIL bz_not_taken got %h want 010", pc_o); end
    endtask

    task automatic test_jsb_ret();
        goto_pc(12'h050);
        step(3'd0, 1'b1, jsb(12'h200), 1'b0, 1'b0);
        step(3'd1, 1'b0, 18'h0, 1'b0, 1'b0);
        n_vec++; if (pc_o !== 12'h200) begin n_err++; $display("FAIL jsb got %h want 200", pc_o); end
        step(3'd0, 1'b1, RET, 1'b0, 1'b0);
        step(3'd1, 1'b0, 18'h0, 1'b0, 1'b0);
        n_vec++; if (pc_o !== 12'h051) begin n_err++; $display("FAIL ret got %h want 051", pc_o); end
    endtask

    task automatic test_nested();
        logic [11:0] pushed [9];
        logic [11:0] want;
        logic [11:0] start;
        start = pc_o;
        for (int i = 0; i < 9; i++) begin
            pushed[i] = (i == 0) ? start + 12'd1 : 12'h100 + 12'(16 * (i - 1)) + 12'd1;
            step(3'd0, 1'b1, jsb(12'h100 + 12'(16 * i)), 1'b0, 1'b0);
            step(3'd1, 1'b0, 18'h0, 1'b0, 1'b0);
            n_vec++; if (pc_o !== 12'h100 + 12'(16 * i)) begin n_err++; $display("FAIL nest_jsb%0d got %h want %h", i, pc_o, 12'h100 + 12'(16 * i)); end
            want = (i == 8) ? ERR_EN : 1'b0;
            n_vec++; if (stack_err_o !== want[0]) begin n_err++; $display("FAIL nest_err_push%0d got %b want %b", i, stack_err_o, want[0]); end
        end
        for (int i = 0; i < 9; i++) begin
            step(3'd0, 1'b1, RET, 1'b0, 1'b0);
            step(3'd1, 1'b0, 18'h0, 1'b0, 1'b0);
            // ninth push overwrote the oldest entry; ninth pop reads that slot again
            if (i < 8) want = pushed[8 - i];
            else       want = ERR_EN ? 12'h000 : pushed[8];
            n_vec++; if (pc_o !== want) begin n_err++; $display("FAIL nest_ret%0d got %h want %h", i, pc_o, want); end
        end
        n_vec++; if (stack_err_o !== ERR_EN) begin n_err++; $display("FAIL nest_err_final got %b want %b", stack_err_o, ERR_EN); end
    endtask

    task automatic test_int_reti();
        goto_pc(12'h033);
        step(3'd0, 1'b1, 18'h0, 1'b0, 1'b0);
        step(3'd5, 1'b0, 18'h0, 1'b0, 1'b0);
        n_vec++; if (pc_o !== 12'h001) begin n_err++; $display("FAIL int_vec got %h want 001", pc_o); end
        step(3'd0, 1'b1, RETI, 1'b0, 1'b0);
        step(3'd1, 1'b0, 18'h0, 1'b0, 1'b0);
        n_vec++; if (pc_o !== 12'h034) begin n_err++; $display("FAIL reti got %h want 034", pc_o); end
    endtask

    task automatic test_wait();
        goto_pc(12'h01F);
        step(3'd0, 1'b1, WAIT, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(3'd1, 1'b0, 18'h0, 1'($urandom), 1'($urandom));
            n_vec++; if (pc_o !== 12'h020 || ir_o !== WAIT) begin n_err++; $display("FAIL wait_hold%0d got pc=%h ir=%h want 020/%h", i, pc_o, ir_o, WAIT); end
        end
    endtask

    task automatic test_reset_mid();
        state_i = 3'd0; inst_ack_i = 1'b0;
        #2;
        n_vec++; if (inst_stb_o !== 1'b1) begin n_err++; $display("FAIL mid_stb_pre got %b want 1", inst_stb_o); end
        rst_i = 1'b1;
        #1;
        n_vec++; if (inst_stb_o !== 1'b0 || pc_o !== 12'h000) begin n_err++; $display("FAIL mid_async got stb=%b pc=%h want 0/000", inst_stb_o, pc_o); end
        inst_ack_i = 1'b1; inst_dat_i = 18'h00123;
        @(posedge clk); #1;
        n_vec++; if (pc_o !== 12'h000 || ir_o !== 18'h0 || stack_err_o !== 1'b0) begin n_err++; $display("FAIL mid_ack_ignored got pc=%h ir=%h err=%b want 000/0/0", pc_o, ir_o, stack_err_o); end
        rst_i = 1'b0; inst_ack_i = 1'b0;
        model_reset();
        step(3'd0, 1'b1, 18'h00ABC, 1'b0, 1'b0);
        n_vec++; if (pc_o !== 12'h001 || ir_o !== 18'h00ABC) begin n_err++; $display("FAIL mid_recover got pc=%h ir=%h want 001/00abc", pc_o, ir_o); end
    endtask

    task automatic test_random();
        logic [2:0]  st;
        logic [17:0] dat;
        for (int i = 0; i < 600; i++) begin
            case ($urandom % 8)
                0, 1, 2, 7: st = 3'd0;
                3, 4:       st = 3'd1;
                5:          st = 3'd5;
                default:    st = 3'($urandom_range(2, 4));
            endcase
            case ($urandom % 7)
                0: dat = jmp(12'($urandom));
                1: dat = jsb(12'($urandom));
                2: dat = RET;
                3: dat = RETI;
                4: dat = br(2'($urandom), 8'($urandom));
                5: dat = {7'b1111110, 3'($urandom), 8'($urandom)};
                default: dat = 18'($urandom);
            endcase
            step(st, 1'($urandom), dat, 1'($urandom), 1'($urandom));
            n_vec++; if (s_stb !== (st == 3'd0) || s_cyc !== (st == 3'd0)) begin n_err++; $display("FAIL rnd_stb%0d got %b/%b want %b", i, s_stb, s_cyc, st == 3'd0); end
            n_vec++; if (pc_o !== m_pc || inst_adr_o !== m_pc) begin n_err++; $display("FAIL rnd_pc%0d got pc=%h adr=%h want %h", i, pc_o, inst_adr_o, m_pc); end
            n_vec++; if (ir_o !== m_ir) begin n_err++; $display("FAIL rnd_ir%0d got %h want %h", i, ir_o, m_ir); end
            n_vec++; if (stack_err_o !== m_err) begin n_err++; $display("FAIL rnd_err%0d got %b want %b", i, stack_err_o, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_late_ack();
        test_pc_wrap();
        test_branch();
        test_jsb_ret();
        test_nested();
        test_int_reti();
        test_wait();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gumnut_fetch_unit.md
Name: gumnut_fetch_unit

Overview:
- Instruction-fetch and program-counter stage of the Gumnut core; sits directly upstream of the control FSM and drives its IR and inst_ack_i inputs.
- Follows the FSM state to run the instruction-bus handshake, latch the 18-bit instruction register and advance the 12-bit PC.
- Applies control transfers: branch, jmp, jsb, ret, reti and the interrupt vector.
- Holds the subroutine return stack and the saved interrupt PC.

Parameters:
- STACK_DEPTH, 8, number of return-stack entries; power of two, 2..16.
- INT_VECTOR, 12'h001, PC value loaded on interrupt entry.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- state_i  in  3  FSM state: 000 fetch, 001 decode, 010 execute, 011 mem, 100 write-back, 101 int.
- zero_i  in  1  ALU zero flag, valid during decode.
- carry_i  in  1  ALU carry flag, valid during decode.
- inst_cyc_o  out  1  instruction bus cycle.
- inst_stb_o  out  1  instruction bus strobe.
- inst_adr_o  out  12  instruction address; always equals pc_o.
- inst_dat_i  in  18  instruction word from memory.
- inst_ack_i  in  1  instruction bus acknowledge; also routed to the FSM.
- ir_o  out  18  instruction register, feeds the FSM IR input.
- pc_o  out  12  current PC.
- stack_err_o  out  1  sticky return-stack error.

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-high on rst_i.
- Reset values: pc=0, ir=0, int_pc=0, stack pointer=0, stack entry count=0, stack_err_o=0.
- inst_cyc_o and inst_stb_o are combinational: 1 when state_i==000 and rst_i==0, otherwise 0.
- Fetch (state_i==000) with inst_ack_i=1: ir<=inst_dat_i; pc<=pc+1, modulo 4096 (12'hFFF wraps to 12'h000).
- Fetch with inst_ack_i=0: ir and pc hold; strobe stays asserted.
- Decode (state_i==001) acts on ir, one update per decode cycle:
  - Branch, ir[17:12]==111110, condition selected by ir[11:10]: 00 bz (zero_i=1), 01 bnz (zero_i=0), 10 bc (carry_i=1), 11 bnc (carry_i=0).
  - Branch taken: pc<=pc+sign_extend(ir[7:0]), modulo 4096. Not taken: pc holds.
  - Jump, ir[17:13]==11110: ir[12]=0 jmp, pc<=ir[11:0]; ir[12]=1 jsb, push pc, then pc<=ir[11:0].
  - Misc, ir[17:11]==1111110, ir[10:8]: 000 ret, pop into pc; 001 reti, pc<=int_pc; all other codes, no pc change.
  - wait and stby hold decode for many cycles; repeated decode cycles of those codes cause no further change.
  - All other instruction classes in decode: no change.
- Int state (state_i==101), one cycle: int_pc<=pc, pc<=INT_VECTOR. The pc saved is the next instruction to execute.
- Execute, mem and write-back states: no register change.
- Return stack is circular. Push writes entry[sp] then sp<=sp+1. Pop sets sp<=sp-1 and pc<=entry[sp-1]. Both wrap modulo STACK_DEPTH.
- Entry count saturates at 0 and STACK_DEPTH and drives error detection.
- Push and pop never occur in the same cycle, since the decode actions are mutually exclusive.
- Reset asserted mid-handshake: strobe drops immediately and all state returns to reset values. An ack arriving during reset is ignored.

Optional Feature:
- Macro GUMNUT_FETCH_STACK_ERR_EN.
- Defined:
  - Entry count is maintained.
  - stack_err_o goes to 1 on the clock edge of a push when count==STACK_DEPTH (the oldest entry is still overwritten), or of a pop when count==0.
  - A pop when count==0 loads pc<=12'h000 instead of the stale entry.
  - stack_err_o is cleared only by rst_i.
- Not defined: the count logic is removed, stack_err_o is tied to 0, and pop on empty returns entry[sp-1] unchanged.

Test Plan:
- Reset, then state_i=000 with a 2-cycle-late ack carrying inst_dat_i=18'h0_0123 -> strobe high for 3 cycles; ir_o=18'h0_0123; pc_o 0->1 on the ack edge only.
- pc=12'hFFF, fetch with ack -> pc_o=12'h000.
- ir=bz with disp 8'hFC, zero_i=1, pc=12'h010, decode -> pc_o=12'h00C. Same with zero_i=0 -> pc_o holds 12'h010.
- jsb 12'h200 at pc=12'h051, then decode ret -> pc_o=12'h200, then 12'h051. Nine nested jsb followed by nine ret -> with the macro defined, stack_err_o=1 after the ninth push and the final ret returns wrong data as specified.
- pc=12'h034, state_i=101 -> pc_o=12'h001. Later decode reti -> pc_o=12'h034.
- Decode of wait held 5 cycles with pc=12'h020 -> pc_o stays 12'h020. rst_i pulsed during fetch -> inst_stb_o=0 in the same cycle, pc_o=0.
